ovi_issue_scheduler: RTL and testbench

//  Sits between the core-side issue/completed buses and the OVI vpu issue/dispatch/completed buses.

---
 rtl/ovi_issue_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_ovi_issue_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovi_issue_scheduler.sv
// ovi_issue_scheduler: bridges the core issue/commit/kill/completion interface to the
// OVI vector unit. Hands out scoreboard ids, holds issue back while the VPU has no
// credits, dispatches in order (senior or kill) and routes completions back to the core.
module ovi_issue_scheduler #(
  parameter int NUM_SBID     = 32,
  parameter int INIT_CREDITS = 4,
  parameter int INSTR_W      = 32,
  parameter int DATA_W       = 64,
  localparam int SBID_W      = $clog2(NUM_SBID)
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               core_valid,
  output logic               core_ready,
  input  logic [INSTR_W-1:0] core_instr,
  input  logic [DATA_W-1:0]  core_opnd,
  input  logic               core_wb,
  input  logic [4:0]         core_dst,
  input  logic               core_commit,
  input  logic               core_kill,
  output logic               vpu_issue_valid,
  output logic [INSTR_W-1:0] vpu_issue_instr,
  output logic [DATA_W-1:0]  vpu_issue_opnd,
  output logic [SBID_W-1:0]  vpu_issue_sb_id,
  input  logic               vpu_issue_credit,
  output logic               vpu_disp_valid,
  output logic [SBID_W-1:0]  vpu_disp_sb_id,
  output logic               vpu_disp_next_senior,
  output logic               vpu_disp_kill,
  input  logic               vpu_cmpl_valid,
  input  logic [SBID_W-1:0]  vpu_cmpl_sb_id,
  input  logic [DATA_W-1:0]  vpu_cmpl_dest_reg,
  input  logic               vpu_cmpl_illegal,
  output logic               core_cmpl_valid,
  output logic [DATA_W-1:0]  core_cmpl_data,
  output logic               core_cmpl_wb,
  output logic [4:0]         core_cmpl_dst,
  output logic               core_cmpl_illegal,
  output logic               err_cmpl
);

  localparam int CRED_W = $clog2(INIT_CREDITS + 1);
  localparam int CNT_W  = SBID_W + 1;

  typedef enum logic [0:0] {ST_RUN, ST_KILL} state_e;

  state_e state_q, state_d;

  logic [NUM_SBID-1:0] alloc_q, alloc_d;
  logic [NUM_SBID-1:0] slotWb_q;
  logic [4:0]          slotDst_q [NUM_SBID];

  logic [SBID_W-1:0] fifo_q [NUM_SBID];
  logic [SBID_W-1:0] rdPtr_q, rdPtr_d;
  logic [SBID_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CRED_W-1:0] credit_q, credit_d;

  logic              anyFree;
  logic [SBID_W-1:0] freeIdx;
  logic              issueFire;
  logic              fifoNotEmpty;
  logic [SBID_W-1:0] fifoHead;
  logic              popRun;
  logic              popKill;
  logic              pop;
  logic              cmplHit;
  logic              cmplMiss;

  logic               issueValid_q;
  logic [INSTR_W-1:0] issueInstr_q;
  logic [DATA_W-1:0]  issueOpnd_q;
  logic [SBID_W-1:0]  issueSbId_q;
  logic               dispValid_q;
  logic [SBID_W-1:0]  dispSbId_q;
  logic               dispSenior_q;
  logic               dispKill_q;
  logic               cmplValid_q;
  logic [DATA_W-1:0]  cmplData_q;
  logic               cmplWb_q;
  logic [4:0]         cmplDst_q;
  logic               cmplIllegal_q;
  logic               errCmpl_q;

  // Circular pointer advance that also works for a slot count that is not a power of two.
  function automatic logic [SBID_W-1:0] ptrInc(input logic [SBID_W-1:0] p);
    if (p == SBID_W'(NUM_SBID - 1)) return '0;
    return p + SBID_W'(1);
  endfunction

  // Priority-find the lowest-index free scoreboard slot.
  always_comb begin
    anyFree = 1'b0;
    freeIdx = '0;
    for (int i = NUM_SBID - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        anyFree = 1'b1;
        freeIdx = SBID_W'(i);
      end
    end
  end

  // Reset gating keeps core_ready low while the block is held in reset.
  assign core_ready   = rst_l & (state_q == ST_RUN) & (credit_q != '0) & anyFree & ~core_kill;
  assign issueFire    = core_valid & core_ready;
  assign fifoNotEmpty = (count_q != '0);
  assign fifoHead     = fifo_q[rdPtr_q];
  assign cmplHit      = vpu_cmpl_valid & alloc_q[vpu_cmpl_sb_id];
  assign cmplMiss     = vpu_cmpl_valid & ~alloc_q[vpu_cmpl_sb_id];
  assign pop          = popRun | popKill;

  // Run/kill sequencing: a kill in RUN drops that cycle's commit, then KILL drains one entry per cycle.
  always_comb begin
    state_d = state_q;
    popRun  = 1'b0;
    popKill = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (core_kill && fifoNotEmpty) begin
          state_d = ST_KILL;
        end else if (core_commit && fifoNotEmpty) begin
          popRun = 1'b1;
        end
      end
      ST_KILL: begin
        popKill = fifoNotEmpty;
        if (count_q <= CNT_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Next-state for slot occupancy, dispatch queue bookkeeping and the credit counter.
  always_comb begin
    alloc_d  = alloc_q;
    rdPtr_d  = rdPtr_q;
    wrPtr_d  = wrPtr_q;
    count_d  = count_q;
    credit_d = credit_q;
    if (issueFire) alloc_d[freeIdx] = 1'b1;
    if (popKill) alloc_d[fifoHead] = 1'b0;
    if (cmplHit) alloc_d[vpu_cmpl_sb_id] = 1'b0;
    if (issueFire) wrPtr_d = ptrInc(wrPtr_q);
    if (pop) rdPtr_d = ptrInc(rdPtr_q);
    if (issueFire && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!issueFire && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    if (issueFire && !vpu_issue_credit) begin
      credit_d = credit_q - CRED_W'(1);
    end else if (!issueFire && vpu_issue_credit && (credit_q != CRED_W'(INIT_CREDITS))) begin
      credit_d = credit_q + CRED_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= ST_RUN;
      alloc_q  <= '0;
      rdPtr_q  <= '0;
      wrPtr_q  <= '0;
      count_q  <= '0;
      credit_q <= CRED_W'(INIT_CREDITS);
    end else begin
      state_q  <= state_d;
      alloc_q  <= alloc_d;
      rdPtr_q  <= rdPtr_d;
      wrPtr_q  <= wrPtr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // Per-slot writeback info and the in-order dispatch queue, written on each accepted issue.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      slotWb_q <= '0;
      for (int i = 0; i < NUM_SBID; i++) begin
        slotDst_q[i] <= '0;
        fifo_q[i]    <= '0;
      end
    end else if (issueFire) begin
      slotWb_q[freeIdx]  <= core_wb;
      slotDst_q[freeIdx] <= core_dst;
      fifo_q[wrPtr_q]    <= freeIdx;
    end
  end

  // Registered VPU issue, dispatch and core completion outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      issueValid_q  <= 1'b0;
      issueInstr_q  <= '0;
      issueOpnd_q   <= '0;
      issueSbId_q   <= '0;
      dispValid_q   <= 1'b0;
      dispSbId_q    <= '0;
      dispSenior_q  <= 1'b0;
      dispKill_q    <= 1'b0;
      cmplValid_q   <= 1'b0;
      cmplData_q    <= '0;
      cmplWb_q      <= 1'b0;
      cmplDst_q     <= '0;
      cmplIllegal_q <= 1'b0;
      errCmpl_q     <= 1'b0;
    end else begin
      issueValid_q <= issueFire;
      if (issueFire) begin
        issueInstr_q <= core_instr;
        issueOpnd_q  <= core_opnd;
        issueSbId_q  <= freeIdx;
      end
      dispValid_q  <= pop;
      dispSenior_q <= popRun;
      dispKill_q   <= popKill;
      if (pop) dispSbId_q <= fifoHead;
      cmplValid_q <= cmplHit;
      errCmpl_q   <= cmplMiss;
      if (cmplHit) begin
        cmplData_q    <= vpu_cmpl_dest_reg;
        cmplWb_q      <= slotWb_q[vpu_cmpl_sb_id] & ~vpu_cmpl_illegal;
        cmplDst_q     <= slotDst_q[vpu_cmpl_sb_id];
        cmplIllegal_q <= vpu_cmpl_illegal;
      end
    end
  end

  assign vpu_issue_valid      = issueValid_q;
  assign vpu_issue_instr      = issueInstr_q;
  assign vpu_issue_opnd       = issueOpnd_q;
  assign vpu_issue_sb_id      = issueSbId_q;
  assign vpu_disp_valid       = dispValid_q;
  assign vpu_disp_sb_id       = dispSbId_q;
  assign vpu_disp_next_senior = dispSenior_q;
  assign vpu_disp_kill        = dispKill_q;
  assign core_cmpl_valid      = cmplValid_q;
  assign core_cmpl_data       = cmplData_q;
  assign core_cmpl_wb         = cmplWb_q;
  assign core_cmpl_dst        = cmplDst_q;
  assign core_cmpl_illegal    = cmplIllegal_q;
  assign err_cmpl             = errCmpl_q;

endmodule

// File: tb/tb_ovi_issue_scheduler.sv
// tb_ovi_issue_scheduler: directed checks of issue, credit gating, in-order dispatch,
// kill draining, completion routing and asynchronous reset of ovi_issue_scheduler.
module tb_ovi_issue_scheduler;

  logic        clk;
  logic        rst_l;
  logic        core_valid;
  logic        core_ready;
  logic [31:0] core_instr;
  logic [63:0] core_opnd;
  logic        core_wb;
  logic [4:0]  core_dst;
  logic        core_commit;
  logic        core_kill;
  logic        vpu_issue_valid;
  logic [31:0] vpu_issue_instr;
  logic [63:0] vpu_issue_opnd;
  logic [4:0]  vpu_issue_sb_id;
  logic        vpu_issue_credit;
  logic        vpu_disp_valid;
  logic [4:0]  vpu_disp_sb_id;
  logic        vpu_disp_next_senior;
  logic        vpu_disp_kill;
  logic        vpu_cmpl_valid;
  logic [4:0]  vpu_cmpl_sb_id;
  logic [63:0] vpu_cmpl_dest_reg;
  logic        vpu_cmpl_illegal;
  logic        core_cmpl_valid;
  logic [63:0] core_cmpl_data;
  logic        core_cmpl_wb;
  logic [4:0]  core_cmpl_dst;
  logic        core_cmpl_illegal;
  logic        err_cmpl;

  int checks = 0;
  int errors = 0;

  ovi_issue_scheduler dut (
    .clk                  (clk),
    .rst_l                (rst_l),
    .core_valid           (core_valid),
    .core_ready           (core_ready),
    .core_instr           (core_instr),
    .core_opnd            (core_opnd),
    .core_wb              (core_wb),
    .core_dst             (core_dst),
    .core_commit          (core_commit),
    .core_kill            (core_kill),
    .vpu_issue_valid      (vpu_issue_valid),
    .vpu_issue_instr      (vpu_issue_instr),
    .vpu_issue_opnd       (vpu_issue_opnd),
    .vpu_issue_sb_id      (vpu_issue_sb_id),
    .vpu_issue_credit     (vpu_issue_credit),
    .vpu_disp_valid       (vpu_disp_valid),
    .vpu_disp_sb_id       (vpu_disp_sb_id),
    .vpu_disp_next_senior (vpu_disp_next_senior),
    .vpu_disp_kill        (vpu_disp_kill),
    .vpu_cmpl_valid       (vpu_cmpl_valid),
    .vpu_cmpl_sb_id       (vpu_cmpl_sb_id),
    .vpu_cmpl_dest_reg    (vpu_cmpl_dest_reg),
    .vpu_cmpl_illegal     (vpu_cmpl_illegal),
    .core_cmpl_valid      (core_cmpl_valid),
    .core_cmpl_data       (core_cmpl_data),
    .core_cmpl_wb         (core_cmpl_wb),
    .core_cmpl_dst        (core_cmpl_dst),
    .core_cmpl_illegal    (core_cmpl_illegal),
    .err_cmpl             (err_cmpl)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the single-bit control inputs for the coming cycle.
  task automatic applyStimulus(input logic valid, input logic commit, input logic kill, input logic credit);
    core_valid       = valid;
    core_commit      = commit;
    core_kill        = kill;
    vpu_issue_credit = credit;
  endtask

  // Advance to just after the next rising edge, where registered outputs are stable.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Return every input to idle.
  task automatic clearInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    core_instr        = '0;
    core_opnd         = '0;
    core_wb           = 1'b0;
    core_dst          = '0;
    vpu_cmpl_valid    = 1'b0;
    vpu_cmpl_sb_id    = '0;
    vpu_cmpl_dest_reg = '0;
    vpu_cmpl_illegal  = 1'b0;
  endtask

  // Hold reset across a rising edge and release it between edges.
  task automatic doReset();
    clearInputs();
    rst_l = 1'b0;
    nextCycle();
    nextCycle();
    rst_l = 1'b1;
    #1;
  endtask

  // Directed sequence of scenarios, each starting from a fresh reset.
  initial begin
    clearInputs();
    rst_l = 1'b0;
    nextCycle();
    $display("[TB] reset state");
    checkOutput("rst_issue_valid", vpu_issue_valid, 0);
    checkOutput("rst_disp_valid", vpu_disp_valid, 0);
    checkOutput("rst_cmpl_valid", core_cmpl_valid, 0);
    checkOutput("rst_err", err_cmpl, 0);
    checkOutput("rst_ready_in_reset", core_ready, 0);
    rst_l = 1'b1;
    #1;
    checkOutput("rst_ready_after", core_ready, 1);

    $display("[TB] scenario 1: four credits, fifth stalls; extra credit at full is dropped");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      core_instr = 32'(100 + k);
      core_opnd  = 64'(1000 + k);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("s1_ready", core_ready, 1);
      nextCycle();
      checkOutput("s1_issue_valid", vpu_issue_valid, 1);
      checkOutput("s1_issue_sb_id", vpu_issue_sb_id, 64'(k));
      checkOutput("s1_issue_instr", vpu_issue_instr, 64'(100 + k));
      checkOutput("s1_issue_opnd", vpu_issue_opnd, 64'(1000 + k));
    end
    core_instr = 32'd104;
    #1;
    checkOutput("s1_ready_stalled", core_ready, 0);
    nextCycle();
    checkOutput("s1_no_fifth_issue", vpu_issue_valid, 0);

    $display("[TB] scenario 2: credit return releases the stall");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("s2_ready_after_credit", core_ready, 1);
    nextCycle();
    checkOutput("s2_issue_valid", vpu_issue_valid, 1);
    checkOutput("s2_issue_sb_id", vpu_issue_sb_id, 4);
    checkOutput("s2_issue_instr", vpu_issue_instr, 104);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    core_instr = 32'd105;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("s2_issue_sb_id_5", vpu_issue_sb_id, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("s2_credit_kept", core_ready, 1);

    $display("[TB] scenario 3: in-order senior dispatch and completion routing");
    doReset();
    core_wb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      core_instr = 32'(200 + k);
      core_dst   = 5'(6 + k);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("s3_issue_sb_id", vpu_issue_sb_id, 64'(k));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput("s3_disp_valid", vpu_disp_valid, 1);
      checkOutput("s3_disp_sb_id", vpu_disp_sb_id, 64'(k));
      checkOutput("s3_disp_senior", vpu_disp_next_senior, 1);
      checkOutput("s3_disp_kill", vpu_disp_kill, 0);
    end
    nextCycle();
    checkOutput("s3_commit_empty_ignored", vpu_disp_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    vpu_cmpl_valid    = 1'b1;
    vpu_cmpl_sb_id    = 5'd1;
    vpu_cmpl_dest_reg = 64'hDEAD;
    vpu_cmpl_illegal  = 1'b0;
    nextCycle();
    vpu_cmpl_valid = 1'b0;
    checkOutput("s3_cmpl_valid", core_cmpl_valid, 1);
    checkOutput("s3_cmpl_data", core_cmpl_data, 64'hDEAD);
    checkOutput("s3_cmpl_dst", core_cmpl_dst, 7);
    checkOutput("s3_cmpl_wb", core_cmpl_wb, 1);
    checkOutput("s3_cmpl_illegal", core_cmpl_illegal, 0);
    checkOutput("s3_cmpl_err", err_cmpl, 0);
    core_instr = 32'd210;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("s3_reuse_sb_id", vpu_issue_sb_id, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] scenario 4: kill drains the undispatched entries");
    doReset();
    core_wb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      core_dst = 5'(10 + k);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("s4_issue_sb_id", vpu_issue_sb_id, 64'(k));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    nextCycle();
    checkOutput("s4_commit_sb_id", vpu_disp_sb_id, 0);
    checkOutput("s4_commit_senior", vpu_disp_next_senior, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("s4_ready_kill_cycle", core_ready, 0);
    nextCycle();
    checkOutput("s4_commit_dropped", vpu_disp_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("s4_ready_in_kill", core_ready, 0);
    for (int k = 1; k < 4; k++) begin
      nextCycle();
      checkOutput("s4_kill_disp_valid", vpu_disp_valid, 1);
      checkOutput("s4_kill_disp_kill", vpu_disp_kill, 1);
      checkOutput("s4_kill_disp_senior", vpu_disp_next_senior, 0);
      checkOutput("s4_kill_disp_sb_id", vpu_disp_sb_id, 64'(k));
      checkOutput("s4_kill_ready", core_ready, (k == 3) ? 64'd1 : 64'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("s4_freed_sb_id", vpu_issue_sb_id, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("s4_no_more_disp", vpu_disp_valid, 0);

    $display("[TB] scenario 5: illegal completion and completion of a free slot");
    doReset();
    core_wb  = 1'b1;
    core_dst = 5'd3;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("s5_issue_sb_id", vpu_issue_sb_id, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    vpu_cmpl_valid    = 1'b1;
    vpu_cmpl_sb_id    = 5'd0;
    vpu_cmpl_dest_reg = 64'h1234;
    vpu_cmpl_illegal  = 1'b1;
    nextCycle();
    checkOutput("s5_cmpl_valid", core_cmpl_valid, 1);
    checkOutput("s5_cmpl_wb_masked", core_cmpl_wb, 0);
    checkOutput("s5_cmpl_illegal", core_cmpl_illegal, 1);
    checkOutput("s5_cmpl_dst", core_cmpl_dst, 3);
    checkOutput("s5_cmpl_data", core_cmpl_data, 64'h1234);
    vpu_cmpl_sb_id   = 5'd9;
    vpu_cmpl_illegal = 1'b0;
    nextCycle();
    checkOutput("s5_free_no_cmpl", core_cmpl_valid, 0);
    checkOutput("s5_free_err", err_cmpl, 1);
    vpu_cmpl_valid = 1'b0;
    nextCycle();
    checkOutput("s5_err_pulse_end", err_cmpl, 0);

    $display("[TB] scenario 6: asynchronous reset while draining a kill");
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("s6_kill_disp_valid", vpu_disp_valid, 1);
    checkOutput("s6_kill_disp_kill", vpu_disp_kill, 1);
    rst_l = 1'b0;
    #1;
    checkOutput("s6_async_disp_valid", vpu_disp_valid, 0);
    checkOutput("s6_async_disp_kill", vpu_disp_kill, 0);
    checkOutput("s6_async_ready", core_ready, 0);
    nextCycle();
    rst_l = 1'b1;
    #1;
    checkOutput("s6_ready_after_release", core_ready, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("s6_issue_sb_id", vpu_issue_sb_id, 64'(k));
    end
    #1;
    checkOutput("s6_credits_exhausted", core_ready, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("s6_fifo_fresh_sb_id", vpu_disp_sb_id, 0);
    checkOutput("s6_fifo_fresh_senior", vpu_disp_next_senior, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
